// File: rtl/counter_share_arbiter_if.sv
// Handshake bundle between the shared interval counter and its requesters.
// master = requester side, slave = arbiter side.
interface counter_share_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len_i;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  modport master (
    output req, len_i,
    input  grant, done, busy, q
  );

  modport slave (
    input  req, len_i,
    output grant, done, busy, q
  );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin owner selection for one shared up-counter used as an interval timer.
// The owner holds the counter for len+1 cycles, then receives a one-cycle done pulse.
module counter_share_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  counter_share_arbiter_if.slave  bus
);
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [PtrW-1:0]  r_ptr, w_ptr_d;
  logic [PtrW-1:0]  w_win, w_idx;
  logic             w_found;
  logic [WIDTH-1:0] r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_len, w_len_d;
  logic [NREQ-1:0]  r_grant, w_grant_d;
  logic [NREQ-1:0]  r_done, w_done_d;
  logic             w_owner_req;
  logic [NREQ-1:0]  w_one;

  assign w_one       = {{(NREQ-1){1'b0}}, 1'b1};
  assign w_owner_req = bus.req[r_ptr];

  // Search starts just after the last owner, so the last owner ranks lowest.
  always_comb begin
    w_win   = r_ptr;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = PtrW'((32'(r_ptr) + i) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_found) w_state_d = StRun;
      StRun:   if (!w_owner_req || (r_cnt == r_len)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ptr_d   = r_ptr;
    w_cnt_d   = '0;
    w_len_d   = r_len;
    w_grant_d = '0;
    w_done_d  = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_d = w_one << w_win;
          w_len_d   = bus.len_i[32'(w_win)*WIDTH +: WIDTH];
          w_ptr_d   = w_win;
        end
      end
      StRun: begin
        // Abort takes precedence over completion, so no done on a dropped request.
        if (!w_owner_req) begin
          w_grant_d = '0;
        end else if (r_cnt == r_len) begin
          w_done_d = w_one << r_ptr;
        end else begin
          w_cnt_d   = r_cnt + WIDTH'(1);
          w_grant_d = r_grant;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= PtrW'(NREQ - 1);
      r_cnt   <= '0;
      r_len   <= '0;
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
      r_len   <= w_len_d;
      r_grant <= w_grant_d;
      r_done  <= w_done_d;
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.busy  = (r_state == StRun);
  assign bus.q     = r_cnt;

endmodule
